// File: rtl/autorepeat_arbiter.sv
// autorepeat_arbiter: one accelerating auto-repeat timer shared by N level
// requesters. A new owner gets an immediate pulse, then repeat pulses whose
// spacing shrinks by STEP per repeat down to MIN_WALL while its level stays high.
module autorepeat_arbiter #(
   parameter int N        = 4,
   parameter int OW       = 2,
   parameter int CW       = 27,
   parameter int MAX_WALL = 100000000,
   parameter int MIN_WALL = 1000000,
   parameter int STEP     = 3000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  level,
   output logic [N-1:0]  pulse,
   output logic          busy,
   output logic [OW-1:0] owner
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [CW-1:0] MAX_INTERVAL  = CW'(MAX_WALL);
   localparam logic [CW-1:0] MIN_INTERVAL  = CW'(MIN_WALL);
   localparam logic [CW-1:0] STEP_SIZE     = CW'(STEP);
   // One bit wider so MIN_WALL+STEP can exceed the interval range safely.
   localparam logic [CW:0]   DEC_THRESHOLD = (CW+1)'(MIN_WALL + STEP);
   localparam logic [N-1:0]  ONE_HOT_0     = N'(1);

   state_t          state_reg, state_next;
   logic [OW-1:0]   owner_reg, owner_next;
   logic [OW-1:0]   ptr_reg, ptr_next;
   logic [CW-1:0]   interval_reg, interval_next;
   logic [CW-1:0]   counter_reg, counter_next;
   logic [N-1:0]    pulse_reg, pulse_next;
   logic            busy_reg, busy_next;

   logic            grant_found;
   logic [OW-1:0]   grant_idx;
   logic [OW:0]     cand;
   logic            owner_level;
   logic [CW-1:0]   counter_inc;
   logic            expire;
   logic [CW-1:0]   interval_dec;

   assign owner_level = level[owner_reg];
   assign counter_inc = counter_reg + 1'b1;
   assign expire      = (counter_inc == interval_reg);
   // Only subtract when the result stays strictly above the floor; this also
   // guarantees the subtraction can never wrap below zero.
   assign interval_dec = ({1'b0, interval_reg} > DEC_THRESHOLD) ?
                         (interval_reg - STEP_SIZE) : MIN_INTERVAL;

   // Round-robin search from the pointer; lowest offset wins, so scan downwards.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_reg} + (OW+1)'(k);
         if (cand >= (OW+1)'(N)) begin
            cand = cand - (OW+1)'(N);
         end
         if (level[cand[OW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[OW-1:0];
         end
      end
   end

   // State and datapath register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         ptr_reg      <= '0;
         interval_reg <= MAX_INTERVAL;
         counter_reg  <= '0;
         pulse_reg    <= '0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         ptr_reg      <= ptr_next;
         interval_reg <= interval_next;
         counter_reg  <= counter_next;
         pulse_reg    <= pulse_next;
         busy_reg     <= busy_next;
      end
   end

   // Next-state logic: grant in IDLE, count/accelerate or release in ACTIVE.
   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      ptr_next      = ptr_reg;
      interval_next = interval_reg;
      counter_next  = counter_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               state_next    = ACTIVE;
               owner_next    = grant_idx;
               ptr_next      = (grant_idx == OW'(N - 1)) ? '0 : grant_idx + 1'b1;
               interval_next = MAX_INTERVAL;
               counter_next  = '0;
            end
         end
         ACTIVE: begin
            if (!owner_level) begin
               // Release wins over a coincident expiry.
               state_next    = IDLE;
               interval_next = MAX_INTERVAL;
               counter_next  = '0;
            end else if (expire) begin
               counter_next  = '0;
               interval_next = interval_dec;
            end else begin
               counter_next  = counter_inc;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic: compute the values the output registers take next cycle.
   always_comb begin
      pulse_next = '0;
      busy_next  = (state_next == ACTIVE);
      if (state_reg == IDLE && grant_found) begin
         pulse_next = ONE_HOT_0 << grant_idx;
      end else if (state_reg == ACTIVE && owner_level && expire) begin
         pulse_next = ONE_HOT_0 << owner_reg;
      end
   end

   assign pulse = pulse_reg;
   assign busy  = busy_reg;
   assign owner = owner_reg;

endmodule

// File: tb/tb_autorepeat_arbiter.sv
// Directed bench for autorepeat_arbiter: expected pulses are queued with the
// cycle they must appear in; a monitor pops and checks every pulse it sees.
module tb_autorepeat_arbiter;

   localparam int N     = 4;
   localparam int OW    = 2;
   localparam int CW    = 8;
   localparam int MAXW  = 10;
   localparam int MINW  = 4;
   localparam int STEPW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  level = '0;
   logic [N-1:0]  pulse;
   logic          busy;
   logic [OW-1:0] owner;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int cyc;
      int idx;
   } exp_t;
   exp_t exp_q[$];

   autorepeat_arbiter #(
      .N(N), .OW(OW), .CW(CW), .MAX_WALL(MAXW), .MIN_WALL(MINW), .STEP(STEPW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .level(level),
      .pulse(pulse),
      .busy(busy),
      .owner(owner)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, actual, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input int c, input int idx);
      exp_t e;
      e.cyc = c;
      e.idx = idx;
      exp_q.push_back(e);
   endtask

   // Monitor: every nonzero pulse must match the head of the expectation queue.
   always @(negedge clk) begin : monitor
      exp_t e;
      logic [N-1:0] want;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         compared++;
         mismatched++;
         $display("FAIL missing_pulse: got none, required pulse[%0d] at cycle %0d", exp_q[0].idx, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (pulse != '0) begin
         compared++;
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            mismatched++;
            $display("FAIL unexpected_pulse: got pulse=%b at cycle %0d, required none", pulse, cyc);
         end else begin
            e = exp_q.pop_front();
            want = '0;
            want[e.idx] = 1'b1;
            if (pulse != want || int'(owner) != e.idx) begin
               mismatched++;
               $display("FAIL pulse_value: got pulse=%b owner=%0d, required pulse=%b owner=%0d at cycle %0d",
                        pulse, owner, want, e.idx, cyc);
            end else begin
               $display("ok   pulse[%0d] at cycle %0d", e.idx, cyc);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int c;
      int d;
      #12;
      check("reset_pulse", int'(pulse), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_owner", int'(owner), 0);
      @(negedge clk);
      rst = 1'b0;
      step(2);

      // Single tap on level[2] for three sampling edges.
      level = 4'b0100; c = cyc;
      expect_pulse(c + 1, 2);
      step(1);
      check("tap_busy_c0", int'(busy), 1);
      check("tap_owner", int'(owner), 2);
      step(1);
      check("tap_busy_c1", int'(busy), 1);
      step(1);
      check("tap_busy_c2", int'(busy), 1);
      level = 4'b0000;
      step(1);
      check("tap_busy_off", int'(busy), 0);
      step(15);
      check("tap_owner_hold", int'(owner), 2);
      check("tap_queue_empty", exp_q.size(), 0);

      // Hold level[1] for 40 sampling edges: pointer is 3 so 1 is found after wrap.
      level = 4'b0010; c = cyc;
      expect_pulse(c + 1, 1);
      expect_pulse(c + 11, 1);
      expect_pulse(c + 18, 1);
      expect_pulse(c + 22, 1);
      expect_pulse(c + 26, 1);
      expect_pulse(c + 30, 1);
      expect_pulse(c + 34, 1);
      expect_pulse(c + 38, 1);
      step(40);
      check("hold_busy_last", int'(busy), 1);
      level = 4'b0000;
      step(1);
      check("hold_busy_off", int'(busy), 0);
      step(5);
      check("hold_owner", int'(owner), 1);
      check("hold_queue_empty", exp_q.size(), 0);

      // Reset, then simultaneous press of 0 and 3, then hand-over to 3.
      rst = 1'b1;
      step(2);
      check("rst2_owner", int'(owner), 0);
      check("rst2_busy", int'(busy), 0);
      rst = 1'b0;
      step(1);
      level = 4'b1001; c = cyc;
      expect_pulse(c + 1, 0);
      step(1);
      check("simul_owner", int'(owner), 0);
      check("simul_busy", int'(busy), 1);
      step(3);
      level = 4'b1000; d = cyc;
      expect_pulse(d + 2, 3);
      expect_pulse(d + 12, 3);
      step(1);
      check("handover_gap_busy", int'(busy), 0);
      step(1);
      check("handover_busy", int'(busy), 1);
      check("handover_owner", int'(owner), 3);
      step(11);
      level = 4'b0000;
      step(2);
      check("handover_release", int'(busy), 0);

      // Round robin: tap 0 (pointer -> 1), then 0+1 twice.
      level = 4'b0001; c = cyc;
      expect_pulse(c + 1, 0);
      step(1);
      level = 4'b0000;
      step(1);
      check("rr_gap_busy", int'(busy), 0);
      level = 4'b0011;
      expect_pulse(c + 3, 1);
      step(1);
      check("rr_first_owner", int'(owner), 1);
      level = 4'b0000;
      step(1);
      level = 4'b0011;
      expect_pulse(c + 5, 0);
      step(1);
      check("rr_second_owner", int'(owner), 0);
      level = 4'b0000;
      step(3);
      check("rr_idle_busy", int'(busy), 0);

      // Release on the same edge the interval would expire: no pulse.
      level = 4'b0100; c = cyc;
      expect_pulse(c + 1, 2);
      step(10);
      check("rve_busy_before", int'(busy), 1);
      level = 4'b0000;
      step(1);
      check("rve_busy_after", int'(busy), 0);
      check("rve_no_pulse", int'(pulse), 0);
      step(3);

      // Asynchronous reset in the middle of an interval with level[1] held.
      level = 4'b0010; c = cyc;
      expect_pulse(c + 1, 1);
      step(4);
      check("mid_busy_before", int'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_pulse", int'(pulse), 0);
      check("async_busy", int'(busy), 0);
      check("async_owner", int'(owner), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; d = cyc;
      expect_pulse(d + 1, 1);
      expect_pulse(d + 11, 1);
      step(12);
      level = 4'b0000;
      step(2);
      check("post_rst_release", int'(busy), 0);

      step(3);
      check("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/autorepeat_arbiter.md
# autorepeat_arbiter

Shares one accelerating auto-repeat timer among N level inputs (debounced buttons). The first granted requester gets a one-cycle pulse immediately, then repeat pulses whose spacing shrinks by a fixed step down to a floor while its level stays high. The block sits between the button debouncers and the UI/menu logic, replacing per-button repeat logic with a single arbitrated timer.

## Interface

- N, 4: number of requesters, minimum 2.
- OW, 2: owner index width, equal to ceil(log2(N)).
- CW, 27: interval/counter width; must hold MAX_WALL.
- MAX_WALL, 100000000: first repeat interval in cycles (1 s at 100 MHz).
- MIN_WALL, 1000000: interval floor in cycles; 1 ≤ MIN_WALL ≤ MAX_WALL.
- STEP, 3000000: interval decrement applied after each repeat pulse.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- level  in  N  request levels; synchronous to clk and debounced upstream.
- pulse  out  N  one-hot or zero, registered; bit i high for one cycle per repeat event of owner i.
- busy  out  1  registered; high while an owner is held.
- owner  out  OW  registered; index of the current or last owner.

## Operation

- Reset values: pulse=0, busy=0, owner=0, rr pointer=0, interval=MAX_WALL, counter=0, state=IDLE.
- FSM states and transitions:
  - IDLE: If any level bit is high, search round-robin starting at the pointer (wrapping modulo N) and select the first set bit i. Set owner=i, pointer=(i+1) mod N, interval=MAX_WALL, counter=0, then go to ACTIVE. Assert pulse[i] and busy in the next cycle.
  - ACTIVE: Increment counter each cycle. When counter reaches interval, assert pulse[owner] for the next cycle, clear counter, and load the next interval.
    - The next interval is interval−STEP if interval > MIN_WALL+STEP; otherwise it is MIN_WALL.
    - The subtraction must never underflow.
  - Release: If level[owner] is sampled low in ACTIVE, go to IDLE. pulse=0 and busy=0 from the next cycle. Interval and counter are reset to their reset values.
- Release has priority over a simultaneous interval expiry: no pulse is produced.
- Non-owner level bits are ignored while ACTIVE and produce no pulses.
- After a release, other held bits are granted on the following IDLE cycle as fresh presses. They get an immediate pulse and interval=MAX_WALL.
- owner holds its last value in IDLE.
- Asynchronous reset at any time forces all reset values immediately. No pulse is produced on reset deassertion unless a level bit is sampled high in IDLE.

## Timing

- Press latency: level[i] sampled high at edge e in IDLE gives pulse[i]=1 and busy=1 in the cycle after e.
- Repeat spacing: the distance from one pulse cycle to the next equals the interval in force. Intervals run MAX_WALL, then decrease by STEP, clamped at MIN_WALL.
- Release latency: level[owner] sampled low at edge e gives busy=0 in the cycle after e.
- Owner hand-over: busy is low for exactly one cycle between owners.
- pulse is never high for two consecutive cycles when MIN_WALL ≥ 2.

## Test plan

All scenarios use N=4, MAX_WALL=10, MIN_WALL=4, STEP=3, CW=8.

1. **Single tap.** After reset, level[2] is high for 3 cycles (first sampled at edge e0).
   - Required: a single pulse[2] in cycle c0 (the cycle after e0); owner=2; busy high for 3 cycles; no further pulses.
2. **Hold with acceleration.** level[1] is held from edge e0 through edge e0+39 and released at edge e0+40.
   - Required: pulse[1] exactly at c0, c0+10, c0+17, c0+21, c0+25, c0+29, c0+33, c0+37; nothing at c0+41.
3. **Simultaneous press and hand-over.** After reset, level[0] and level[3] are raised together.
   - Required: owner=0.
   - Then drop level[0] while level[3] stays high. Required: busy=0 for one cycle, then owner=3, pulse[3] immediately, and the next pulse 10 cycles later.
4. **Round-robin order.**
   - With the pointer at 1 (after owner 0), press level[0] and level[1] together. Required: owner=1.
   - Release both, then press level[0] and level[1] again. Required: owner=0, since the pointer wrapped to 2.
5. **Release versus expiry.** Drop the owner's level at the same edge on which its counter reaches the interval.
   - Required: no pulse; busy=0 in the next cycle.
6. **Reset mid-hold.** Assert rst asynchronously mid-interval while a level is held.
   - Required: pulse, busy and owner go to 0 immediately.
   - After rst deasserts with the level still high: a pulse one cycle after the first sampling edge, and the next pulse 10 cycles later.
